// File: rtl/lab2_mux_share_arbiter_if.sv
// Shared-channel bundle between the two requesters, the arbiter and the consumer.
// Handshake: a requester holds req high for its whole burst and presents one beat
// of data (plus its last marker) every cycle; a beat is taken on each rising edge
// where req and the matching grant are both high. There is no backpressure: the
// consumer must accept m whenever the one-cycle m_valid strobe is high.
interface lab2_mux_share_arbiter_if #(
  parameter int WIDTH = 2
);
  logic             req_x;
  logic [WIDTH-1:0] x;
  logic             last_x;
  logic             req_y;
  logic [WIDTH-1:0] y;
  logic             last_y;
  logic             gnt_x;
  logic             gnt_y;
  logic             s;
  logic [WIDTH-1:0] m;
  logic             m_valid;
  logic [1:0]       state_dbg;

  // Requester/consumer side.
  modport master (
    output req_x, x, last_x, req_y, y, last_y,
    input  gnt_x, gnt_y, s, m, m_valid, state_dbg
  );

  // Arbiter side.
  modport slave (
    input  req_x, x, last_x, req_y, y, last_y,
    output gnt_x, gnt_y, s, m, m_valid, state_dbg
  );
endinterface

// File: rtl/lab2_mux_share_arbiter.sv
// Round-robin arbiter sharing one registered 2-to-1 mux channel between
// requesters X and Y, with burst support and forced hand-over after MAX_HOLD
// beats while the other side is waiting.
module lab2_mux_share_arbiter #(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 4
) (
  input logic                        clk,
  input logic                        reset,
  lab2_mux_share_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GX   = 2'd1,
    GY   = 2'd2
  } state_t;

  // Counter saturates here; a beat at this count hands over under contention.
  localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             last_y_served;  // 1: Y was served last, so X wins a tie
  logic             s_r;
  logic [WIDTH-1:0] m_r;
  logic             m_valid_r;

  // Grant FSM, beat counter, select and registered channel data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      last_y_served <= 1'b1;
      s_r           <= 1'b0;
      m_r           <= '0;
      m_valid_r     <= 1'b0;
    end else begin
      m_valid_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_x && (!bus.req_y || last_y_served)) begin
            state <= GX;
            s_r   <= 1'b0;
          end else if (bus.req_y) begin
            state <= GY;
            s_r   <= 1'b1;
          end
        end
        GX: begin
          if (bus.req_x) begin
            m_r       <= bus.x;
            m_valid_r <= 1'b1;
          end
          // last_x only matters on a beat, which is implied by req_x here.
          if (!bus.req_x || bus.last_x || (cnt == CNT_MAX && bus.req_y)) begin
            last_y_served <= 1'b0;
            cnt           <= 4'd0;
            if (bus.req_y) begin
              state <= GY;
              s_r   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 4'd1;
          end
        end
        GY: begin
          if (bus.req_y) begin
            m_r       <= bus.y;
            m_valid_r <= 1'b1;
          end
          if (!bus.req_y || bus.last_y || (cnt == CNT_MAX && bus.req_x)) begin
            last_y_served <= 1'b1;
            cnt           <= 4'd0;
            if (bus.req_x) begin
              state <= GX;
              s_r   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants decode straight from the state register, so they can never overlap.
  assign bus.gnt_x     = (state == GX);
  assign bus.gnt_y     = (state == GY);
  assign bus.s         = s_r;
  assign bus.m         = m_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_lab2_mux_share_arbiter.sv
// Bench for lab2_mux_share_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural owner/beat model.
module tb_lab2_mux_share_arbiter;

  localparam int WIDTH    = 2;
  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lab2_mux_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  lab2_mux_share_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- counters ----------------
  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 none, 1 X, 2 Y. beats: beats taken in current grant (unbounded).
  int               md_owner;
  int               md_beats;
  int               md_last_srv;
  logic             md_s;
  logic [WIDTH-1:0] md_m;
  logic             md_mv;
  logic [WIDTH-1:0] exp_q[$];

  task automatic model_step();
    int        other;
    logic      own_req, oth_req, own_last;
    logic [WIDTH-1:0] own_data;
    logic      leave;
    if (reset) begin
      md_owner = 0; md_beats = 0; md_last_srv = 2;
      md_s = 1'b0; md_m = '0; md_mv = 1'b0;
      exp_q.delete();
      return;
    end
    md_mv = 1'b0;
    if (md_owner == 0) begin
      if (bus.req_x && bus.req_y) md_owner = (md_last_srv == 1) ? 2 : 1;
      else if (bus.req_x)         md_owner = 1;
      else if (bus.req_y)         md_owner = 2;
      if (md_owner != 0) md_s = (md_owner == 2);
    end else begin
      other    = (md_owner == 1) ? 2 : 1;
      own_req  = (md_owner == 1) ? bus.req_x  : bus.req_y;
      oth_req  = (md_owner == 1) ? bus.req_y  : bus.req_x;
      own_last = (md_owner == 1) ? bus.last_x : bus.last_y;
      own_data = (md_owner == 1) ? bus.x      : bus.y;
      leave    = 1'b0;
      if (!own_req) begin
        leave = 1'b1;
      end else begin
        md_m  = own_data;
        md_mv = 1'b1;
        exp_q.push_back(own_data);
        md_beats++;
        if (own_last || (md_beats >= MAX_HOLD && oth_req)) leave = 1'b1;
      end
      if (leave) begin
        md_last_srv = md_owner;
        md_beats    = 0;
        md_owner    = oth_req ? other : 0;
        if (md_owner != 0) md_s = (md_owner == 2);
      end
    end
  endtask

  // Scoreboard: compare all outputs against the model every cycle.
  task automatic check_model();
    logic [WIDTH-1:0] e;
    chk("mdl_gnt_x", int'(bus.gnt_x), int'(md_owner == 1));
    chk("mdl_gnt_y", int'(bus.gnt_y), int'(md_owner == 2));
    chk("mdl_s", int'(bus.s), int'(md_s));
    chk("mdl_m", int'(bus.m), int'(md_m));
    chk("mdl_m_valid", int'(bus.m_valid), int'(md_mv));
    if (bus.m_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_m", int'(bus.m), int'(e));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst_v, input logic rx, input logic [WIDTH-1:0] xv,
                      input logic lx, input logic ry, input logic [WIDTH-1:0] yv,
                      input logic ly);
    reset      = rst_v;
    bus.req_x  = rx;
    bus.x      = xv;
    bus.last_x = lx;
    bus.req_y  = ry;
    bus.y      = yv;
    bus.last_y = ly;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst;
    logic             rx;
    logic [WIDTH-1:0] xv;
    logic             lx;
    logic             ry;
    logic [WIDTH-1:0] yv;
    logic             ly;
    logic             e_gx;
    logic             e_gy;
    logic             e_s;
    logic [WIDTH-1:0] e_m;
    logic             e_mv;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n;
    int gx_cycles;
    bit done;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.req_x = 1'b0; bus.x = '0; bus.last_x = 1'b0;
    bus.req_y = 1'b0; bus.y = '0; bus.last_y = 1'b0;

    //          rst rx x  lx ry y  ly | gx gy s  m  mv
    vecs[0]  = '{1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0};  // reset with both requesting
    vecs[1]  = '{1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0};  // grant X next cycle
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 1, 1};  // X burst 1,3,2
    vecs[4]  = '{0, 1, 3, 0, 0, 0, 0,   1, 0, 0, 3, 1};
    vecs[5]  = '{0, 1, 2, 1, 0, 0, 0,   0, 0, 0, 2, 1};  // last -> IDLE
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0};
    vecs[7]  = '{0, 1, 1, 1, 1, 2, 1,   0, 1, 1, 2, 0};  // tie, X served last -> Y
    vecs[8]  = '{0, 1, 1, 1, 1, 2, 1,   1, 0, 0, 2, 1};  // alternate, no gap
    vecs[9]  = '{0, 1, 1, 1, 1, 2, 1,   0, 1, 1, 1, 1};
    vecs[10] = '{0, 1, 1, 1, 1, 2, 1,   1, 0, 0, 2, 1};
    vecs[11] = '{0, 1, 1, 1, 1, 2, 1,   0, 1, 1, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0};  // Y drops, s holds 1

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].rx, vecs[i].xv, vecs[i].lx,
           vecs[i].ry, vecs[i].yv, vecs[i].ly);
      chk($sformatf("vec%0d_gnt_x", i), int'(bus.gnt_x), int'(vecs[i].e_gx));
      chk($sformatf("vec%0d_gnt_y", i), int'(bus.gnt_y), int'(vecs[i].e_gy));
      chk($sformatf("vec%0d_s", i), int'(bus.s), int'(vecs[i].e_s));
      chk($sformatf("vec%0d_m", i), int'(bus.m), int'(vecs[i].e_m));
      chk($sformatf("vec%0d_m_valid", i), int'(bus.m_valid), int'(vecs[i].e_mv));
    end

    // Forced hand-over: X streams with Y waiting -> exactly MAX_HOLD X beats.
    step(0, 1, 2'd1, 0, 1, 2'd2, 0);
    chk("force_grant_x", int'(bus.gnt_x), 1);
    n = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(0, 1, 2'($urandom_range(0, 3)), 0, 1, 2'd2, 0);
      if (bus.m_valid) n++;
      if (bus.gnt_y) done = 1;
    end
    chk("force_switch_seen", int'(done), 1);
    chk("force_x_beats", n, MAX_HOLD);
    chk("force_s", int'(bus.s), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("force_idle", int'(bus.gnt_x | bus.gnt_y), 0);

    // No contention: X keeps the channel past MAX_HOLD.
    step(0, 1, 2'd3, 0, 0, 0, 0);
    n = 0;
    gx_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0, 0);
      if (bus.m_valid) n++;
      if (bus.gnt_x) gx_cycles++;
    end
    chk("stream_beats", n, 10);
    chk("stream_gnt_x", gx_cycles, 10);
    step(0, 1, 2'd0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Y owner drops req with no beat -> IDLE, s and m hold.
    step(0, 0, 0, 0, 1, 2'd3, 0);
    chk("drop_gnt_y", int'(bus.gnt_y), 1);
    step(0, 0, 0, 0, 1, 2'd3, 0);
    step(0, 0, 0, 0, 0, 2'd1, 0);
    chk("drop_gnt_y_low", int'(bus.gnt_y), 0);
    chk("drop_s_hold", int'(bus.s), 1);
    chk("drop_m_hold", int'(bus.m), 3);
    chk("drop_m_valid", int'(bus.m_valid), 0);

    // Reset on the 2nd beat of a Y burst, then a tie goes to X.
    step(0, 0, 0, 0, 1, 2'd1, 0);
    step(0, 0, 0, 0, 1, 2'd1, 0);
    step(1, 0, 0, 0, 1, 2'd2, 0);
    chk("rst_mid_gnt_y", int'(bus.gnt_y), 0);
    chk("rst_mid_s", int'(bus.s), 0);
    chk("rst_mid_m", int'(bus.m), 0);
    chk("rst_mid_m_valid", int'(bus.m_valid), 0);
    step(0, 1, 2'd1, 0, 1, 2'd2, 0);
    chk("rst_tie_gnt_x", int'(bus.gnt_x), 1);
    chk("rst_tie_gnt_y", int'(bus.gnt_y), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0));
      chk("rand_no_overlap", int'(bus.gnt_x & bus.gnt_y), 0);
    end

    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lab2_mux_share_arbiter.md
Name: lab2_mux_share_arbiter

Overview:
Round-robin arbiter that shares the 2-bit 2-to-1 mux output channel between two requesters, X and Y. It drives the mux select `s` from a grant state machine and registers the selected data onto `m` with a one-cycle valid strobe. It supports bursts (last-beat marker) and forced hand-over after MAX_HOLD beats when the other side is waiting. It sits between two lab2 data sources and one shared 2-bit consumer.

Parameters:
WIDTH, 2, data width of x, y, m.
MAX_HOLD, 4, maximum beats per grant while the other requester is waiting (legal 1..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_x  input  1  requester X wants the channel; held high for the whole burst.
x  input  WIDTH  requester X data.
last_x  input  1  current X beat is the final beat of its burst.
req_y  input  1  requester Y request.
y  input  WIDTH  requester Y data.
last_y  input  1  Y final-beat marker.
gnt_x  output  1  X owns the channel (decoded from state register).
gnt_y  output  1  Y owns the channel.
s  output  1  mux select: 0 = x, 1 = y (registered).
m  output  WIDTH  registered shared-channel data.
m_valid  output  1  m carries a new beat this cycle.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.
- Reset values:
  - state = IDLE, gnt_x = gnt_y = 0, s = 0, m = 0, m_valid = 0, beat counter = 0.
  - Last-served pointer = Y, so X wins the first tie.
- States: IDLE, GX, GY. gnt_x = (state == GX); gnt_y = (state == GY). Grants never overlap.
- IDLE:
  - Only req_x: go to GX.
  - Only req_y: go to GY.
  - Both: grant the side that is not the last-served one.
  - Neither: stay in IDLE.
  - Grant is visible the cycle after the request is first sampled.
- Entering GX clears s; entering GY sets s. s holds its value in IDLE.
- Beat: a rising edge where (GX and req_x) or (GY and req_y). On each beat:
  - m <= owner data;
  - m_valid <= 1 for exactly one cycle;
  - counter increments, saturating at MAX_HOLD-1.
- Latency: data sampled at edge N appears on m/m_valid after edge N, i.e. 1 cycle. m holds its value when there is no beat.
- Leaving GX (GY is symmetric):
  - Owner's req drops, with no beat this edge: go to GY if req_y, else IDLE.
  - Beat with last_x = 1: go to GY if req_y, else IDLE.
  - Beat with counter == MAX_HOLD-1 and req_y = 1: forced hand-over to GY, even if last_x = 0. X must re-request to continue.
  - Counter at MAX_HOLD-1 with req_y = 0: keep granting X; no preemption without contention.
- On any exit from GX or GY:
  - last-served <= that side;
  - counter <= 0.
  - Direct GX<->GY switches take no idle cycle.
- MAX_HOLD = 1 gives strict beat-by-beat alternation under contention.
- Reset asserted mid-burst: at the next edge all state returns to reset values and the burst is lost. No partial beat is emitted on m_valid that cycle.
- last_x/last_y are ignored when there is no beat or the side is not granted.

Test Plan:
1. Reset held 2 cycles with req_x = req_y = 1 -> gnt_x = gnt_y = 0, s = 0, m = 0, m_valid = 0. After release: gnt_x = 1 next cycle, s = 0.
2. X-only burst x = 1, 3, 2 with last_x on the 3rd beat, req_y = 0 -> m = 1, 3, 2 with m_valid high for 3 consecutive cycles, each one cycle after its beat; then IDLE, gnt_x = 0, s stays 0.
3. Both requesting continuously, single-beat bursts (last = 1 every beat), x = 1, y = 2 -> grants alternate X, Y, X, Y with no idle gap; s toggles 0, 1, 0, 1; m = 1, 2, 1, 2.
4. MAX_HOLD = 4, X streaming with last_x = 0 and req_y high from the start -> exactly 4 X beats, then forced switch: s = 1, gnt_y = 1 on the next cycle. With req_y = 0, X streams 10 beats unbroken.
5. GY owner drops req_y mid-burst with no beat and req_x = 0 -> IDLE the next cycle, s holds 1, m holds the last y value, m_valid = 0.
6. Reset pulsed on the 2nd beat of a Y burst -> after that edge gnt_y = 0, s = 0, m = 0, m_valid = 0. The subsequent tie grants X first.
